// File: rtl/alu_exec_ctrl_if.sv
// Decode-to-execute instruction port: one decoded ALU instruction per handshake.
// An instruction transfers on a rising edge where op_valid && op_ready; fields are only meaningful while op_valid is high.
interface alu_exec_ctrl_if #(
  parameter int OP_W    = 4,
  parameter int RADDR_W = 3
);
  logic               op_valid;
  logic               op_ready;
  logic [OP_W-1:0]    op_code;
  logic [RADDR_W-1:0] rs_a;
  logic [RADDR_W-1:0] rs_b;
  logic [RADDR_W-1:0] rd;

  modport master (output op_valid, op_code, rs_a, rs_b, rd, input op_ready);
  modport slave  (input op_valid, op_code, rs_a, rs_b, rd, output op_ready);
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller: reads two registers, runs the external ALU, writes back
// the result and owns the PSR. One instruction every four cycles (IDLE/READ/EXEC/WB).
module alu_exec_ctrl #(
  parameter int DATA_W  = 8,
  parameter int OP_W    = 4,
  parameter int APSR_W  = 4,
  parameter int PSR_W   = 8,
  parameter int RADDR_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  alu_exec_ctrl_if.slave     dec,
  output logic [RADDR_W-1:0] rf_raddr_a,
  output logic [RADDR_W-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0]  rf_rdata_a,
  input  logic [DATA_W-1:0]  rf_rdata_b,
  output logic [OP_W-1:0]    alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [PSR_W-1:0]   alu_psr,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic [APSR_W-1:0]  alu_apsr,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic [PSR_W-1:0]   psr,
  output logic               done,
  output logic [1:0]         state_dbg
);

  localparam logic [OP_W-1:0] ALU_NOP = '0;
  localparam logic [OP_W-1:0] ALU_ADD = OP_W'(1);
  localparam logic [OP_W-1:0] ALU_NOR = OP_W'(10);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t             state, state_nxt;
  logic [OP_W-1:0]    op_q;
  logic               nop_q;
  logic [RADDR_W-1:0] rs_a_q, rs_b_q, rd_q;
  logic [RADDR_W-1:0] raddr_a_q, raddr_b_q;
  logic [DATA_W-1:0]  res_q;
  logic [APSR_W-1:0]  flg_q;
  logic [PSR_W-1:0]   psr_q;
  logic               accept;

  assign accept = (state == IDLE) && dec.op_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dec.op_valid) state_nxt = READ;
      READ:    state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Unknown codes are folded into nop_q at accept so they never write back or touch the PSR.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= ALU_NOP;
      nop_q     <= 1'b1;
      rs_a_q    <= '0;
      rs_b_q    <= '0;
      rd_q      <= '0;
      raddr_a_q <= '0;
      raddr_b_q <= '0;
      res_q     <= '0;
      flg_q     <= '0;
      psr_q     <= '0;
    end else begin
      if (accept) begin
        op_q   <= dec.op_code;
        nop_q  <= (dec.op_code < ALU_ADD) || (dec.op_code > ALU_NOR);
        rs_a_q <= dec.rs_a;
        rs_b_q <= dec.rs_b;
        rd_q   <= dec.rd;
      end
      if (state == READ) begin
        raddr_a_q <= rs_a_q;
        raddr_b_q <= rs_b_q;
      end
      if (state == EXEC) begin
        res_q <= alu_result;
        flg_q <= alu_apsr;
      end
      if (state == WB && !nop_q) psr_q[APSR_W-1:0] <= flg_q;
    end
  end

  // rst gates the write-back strobes so an abort in WB never leaks a write.
  always_comb begin
    dec.op_ready = (state == IDLE);
    rf_raddr_a   = raddr_a_q;
    rf_raddr_b   = raddr_b_q;
    alu_op       = ALU_NOP;
    alu_a        = '0;
    alu_b        = '0;
    rf_we        = 1'b0;
    rf_waddr     = '0;
    rf_wdata     = '0;
    done         = 1'b0;
    case (state)
      READ: begin
        rf_raddr_a = rs_a_q;
        rf_raddr_b = rs_b_q;
      end
      EXEC: begin
        alu_op = nop_q ? ALU_NOP : op_q;
        alu_a  = rf_rdata_a;
        alu_b  = rf_rdata_b;
      end
      WB: begin
        done = !rst;
        if (!nop_q && !rst) begin
          rf_we    = 1'b1;
          rf_waddr = rd_q;
          rf_wdata = res_q;
        end
      end
      default: ;
    endcase
  end

  assign psr       = psr_q;
  assign alu_psr   = psr_q;
  assign state_dbg = state;

endmodule
